// File: rtl/arbitro_sumador.sv
// Round-robin arbiter sharing one combinational adder between up to four requesters.
// Optional signed-overflow flag is built only when ARBITRO_OVERFLOW_EN is defined.

module sumador #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] i_in1,
  input  logic [LEN-1:0] i_in2,
  output logic [LEN-1:0] o_out
);
  assign o_out = i_in1 + i_in2;
endmodule

module arbitro_sumador #(
  parameter int N_REQ = 2,
  parameter int LEN   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ*LEN-1:0] i_op_a,
  input  logic [N_REQ*LEN-1:0] i_op_b,
  output logic [N_REQ-1:0]     o_grant,
  output logic                 o_busy,
  output logic [N_REQ-1:0]     o_ack,
  output logic                 o_valid,
  output logic [1:0]           o_id,
  output logic [LEN-1:0]       o_result
`ifdef ARBITRO_OVERFLOW_EN
  ,
  output logic                 o_overflow
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [LEN-1:0]     op_a_q, op_a_d;
  logic [LEN-1:0]     op_b_q, op_b_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [1:0]         id_q, id_d;
  logic [LEN-1:0]     result_q, result_d;
`ifdef ARBITRO_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic [3:0]         req_pad;
  logic [2:0]         cand;
  logic               sel_found;
  logic [1:0]         sel_idx;
  logic [LEN-1:0]     op_a_sel, op_b_sel;
  logic [N_REQ-1:0]   grant_sel;
  logic [N_REQ-1:0]   id_onehot;
  logic [LEN-1:0]     sum_w;

  sumador #(.LEN(LEN)) u_sumador (
    .i_in1 (op_a_q),
    .i_in2 (op_b_q),
    .o_out (sum_w)
  );

  // Search upward from ptr with wrap; candidates never reach N_REQ, so
  // non-existent requesters cannot win.
  always_comb begin
    req_pad              = '0;
    req_pad[N_REQ-1:0]   = i_req;
    cand                 = '0;
    sel_found            = 1'b0;
    sel_idx              = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(N_REQ)) begin
        cand = cand - 3'(N_REQ);
      end
      if (!sel_found && req_pad[cand[1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    op_a_sel  = '0;
    op_b_sel  = '0;
    grant_sel = '0;
    id_onehot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_idx == 2'(k)) begin
        op_a_sel     = i_op_a[k*LEN +: LEN];
        op_b_sel     = i_op_b[k*LEN +: LEN];
        grant_sel[k] = 1'b1;
      end
      if (id_q == 2'(k)) begin
        id_onehot[k] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = SUMA;
      SUMA:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless its state updates it.
  always_comb begin
    ptr_d    = ptr_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    ack_d    = ack_q;
    valid_d  = valid_q;
    id_d     = id_q;
    result_d = result_q;
`ifdef ARBITRO_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          op_a_d  = op_a_sel;
          op_b_d  = op_b_sel;
          grant_d = grant_sel;
          id_d    = sel_idx;
          busy_d  = 1'b1;
        end
      end
      SUMA: begin
        result_d = sum_w;
        ack_d    = id_onehot;
        valid_d  = 1'b1;
`ifdef ARBITRO_OVERFLOW_EN
        ovf_d    = (op_a_q[LEN-1] == op_b_q[LEN-1]) && (sum_w[LEN-1] != op_a_q[LEN-1]);
`endif
      end
      RESP: begin
        ack_d   = '0;
        valid_d = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (id_q == 2'(N_REQ-1)) ? 2'd0 : id_q + 2'd1;
      end
      default: begin
        ack_d   = '0;
        valid_d = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
`ifdef ARBITRO_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      result_q <= result_d;
`ifdef ARBITRO_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign o_grant  = grant_q;
  assign o_busy   = busy_q;
  assign o_ack    = ack_q;
  assign o_valid  = valid_q;
  assign o_id     = id_q;
  assign o_result = result_q;
`ifdef ARBITRO_OVERFLOW_EN
  assign o_overflow = ovf_q;
`endif

endmodule
